// File: rtl/clk_div_ctrl_if.sv
// Control and status bundle for the two-channel clock-enable scheduler.
// The bench drives the master side and the scheduler sits on the slave side.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             enable;
    logic             cfg_valid;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             fsm_tick;
    logic             fsm_clk_level;
    logic             ila_tick;
    logic             ila_clk_level;
    logic             busy;
    logic             running;

    modport master (
        output enable, cfg_valid, cfg_sel, cfg_div,
        input  cfg_ready, fsm_tick, fsm_clk_level, ila_tick, ila_clk_level,
        input  busy, running
    );

    modport slave (
        input  enable, cfg_valid, cfg_sel, cfg_div,
        output cfg_ready, fsm_tick, fsm_clk_level, ila_tick, ila_clk_level,
        output busy, running
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Two-channel clock-enable scheduler: each channel emits a one-cycle tick and a
// divided level, with divisor updates deferred to half-period boundaries.
module clk_div_chan #(
    parameter int          CNT_W   = 24,
    parameter int unsigned DIV_RST = 125
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             pend,
    output logic             tick,
    output logic             level,
    output logic             active
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } chan_state_e;

    localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    chan_state_e      state_r,   state_nxt_s;
    logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
    logic [CNT_W-1:0] div_act_r, div_act_nxt_s;
    logic [CNT_W-1:0] div_sh_r,  div_sh_nxt_s;
    logic             pend_r,    pend_nxt_s;
    logic             level_r,   level_nxt_s;
    logic             tick_r,    tick_nxt_s;
    logic             counting_s;
    logic             wrap_s;

    assign counting_s = (state_r != ST_IDLE);
    // The counter never passes div_act, so equality is a sufficient wrap test.
    assign wrap_s     = counting_s && (cnt_r == div_act_r);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            div_act_r <= DIV_RST_C;
            div_sh_r  <= CNT_ZERO;
            pend_r    <= 1'b0;
            level_r   <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            div_act_r <= div_act_nxt_s;
            div_sh_r  <= div_sh_nxt_s;
            pend_r    <= pend_nxt_s;
            level_r   <= level_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    // Next-state selection; a stopping channel only parks after a falling toggle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_STOP;
            end
            ST_STOP: begin
                if (enable)                  state_nxt_s = ST_RUN;
                else if (wrap_s && level_r)  state_nxt_s = ST_IDLE;
                else                         state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter, tick/level and divisor update logic
    always_comb begin
        cnt_nxt_s     = cnt_r;
        level_nxt_s   = level_r;
        tick_nxt_s    = 1'b0;
        div_act_nxt_s = div_act_r;
        div_sh_nxt_s  = div_sh_r;
        pend_nxt_s    = pend_r;
        if (counting_s) begin
            if (wrap_s) begin
                cnt_nxt_s   = CNT_ZERO;
                tick_nxt_s  = 1'b1;
                level_nxt_s = ~level_r;
                if (pend_r) begin
                    div_act_nxt_s = div_sh_r;
                    pend_nxt_s    = 1'b0;
                end else begin
                    div_act_nxt_s = div_act_r;
                    pend_nxt_s    = 1'b0;
                end
            end else begin
                cnt_nxt_s  = cnt_r + CNT_ONE;
                tick_nxt_s = 1'b0;
            end
        end else begin
            cnt_nxt_s   = CNT_ZERO;
            level_nxt_s = 1'b0;
            tick_nxt_s  = 1'b0;
        end
        // A write on a wrap cycle lands after the wrap's own update, so it waits a full half-period.
        if (cfg_we) begin
            if (counting_s) begin
                div_sh_nxt_s = cfg_div;
                pend_nxt_s   = 1'b1;
            end else begin
                div_act_nxt_s = cfg_div;
            end
        end else begin
            div_sh_nxt_s = div_sh_r;
        end
    end

    assign pend   = pend_r;
    assign tick   = tick_r;
    assign level  = level_r;
    assign active = counting_s;
endmodule

module clk_div_ctrl #(
    parameter int          CNT_W       = 24,
    parameter int unsigned FSM_DIV_RST = 125,
    parameter int unsigned ILA_DIV_RST = 250000
) (
    input logic          clk,
    input logic          rst_n,
    clk_div_ctrl_if.slave bus
);
    logic pend_fsm_s;
    logic pend_ila_s;
    logic active_fsm_s;
    logic active_ila_s;
    logic we_fsm_s;
    logic we_ila_s;

    // Only the selected, non-pending channel can take a write.
    assign we_fsm_s = bus.cfg_valid & ~bus.cfg_sel & ~pend_fsm_s;
    assign we_ila_s = bus.cfg_valid &  bus.cfg_sel & ~pend_ila_s;

    clk_div_chan #(
        .CNT_W   (CNT_W),
        .DIV_RST (FSM_DIV_RST)
    ) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (bus.enable),
        .cfg_we  (we_fsm_s),
        .cfg_div (bus.cfg_div),
        .pend    (pend_fsm_s),
        .tick    (bus.fsm_tick),
        .level   (bus.fsm_clk_level),
        .active  (active_fsm_s)
    );

    clk_div_chan #(
        .CNT_W   (CNT_W),
        .DIV_RST (ILA_DIV_RST)
    ) u_ila (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (bus.enable),
        .cfg_we  (we_ila_s),
        .cfg_div (bus.cfg_div),
        .pend    (pend_ila_s),
        .tick    (bus.ila_tick),
        .level   (bus.ila_clk_level),
        .active  (active_ila_s)
    );

    assign bus.cfg_ready = bus.cfg_sel ? ~pend_ila_s : ~pend_fsm_s;
    assign bus.busy      = pend_fsm_s | pend_ila_s;
    assign bus.running   = active_fsm_s | active_ila_s;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized scoreboard bench for clk_div_ctrl against a cycle-level reference
// model of the two channels' half-period scheduling.
module tb_clk_div_ctrl;
    localparam int CNT_W = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) bus();

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .FSM_DIV_RST (125),
        .ILA_DIV_RST (250000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ft, fl, it, il, busy, running, ready
    typedef logic [6:0] obs_t;
    obs_t sb_q[$];
    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 run, 2 stopping; pos = cycles into current half-period.
    int m_mode[2];
    int m_pos[2];
    int m_half[2];
    int m_sh[2];
    bit m_pend[2];
    bit m_level[2];
    bit m_tick[2];
    bit a_en, a_valid, a_sel;
    int a_div;

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_mode[ch] = 0; m_pos[ch] = 0; m_sh[ch] = 0;
            m_pend[ch] = 1'b0; m_level[ch] = 1'b0; m_tick[ch] = 1'b0;
        end
        m_half[0] = 125;
        m_half[1] = 250000;
        a_en = 1'b0; a_valid = 1'b0; a_sel = 1'b0; a_div = 0;
    endfunction

    function automatic void model_step();
        bit wr_acc;
        wr_acc = a_valid && !m_pend[a_sel];
        for (int ch = 0; ch < 2; ch++) begin
            int  old_mode;
            bit  bnd;
            old_mode = m_mode[ch];
            bnd = (old_mode != 0) && (m_pos[ch] == m_half[ch]);
            m_tick[ch] = bnd;
            if (old_mode == 0) begin
                m_pos[ch] = 0;
                m_level[ch] = 1'b0;
                m_mode[ch] = a_en ? 1 : 0;
            end else begin
                if (bnd) begin
                    m_level[ch] = !m_level[ch];
                    m_pos[ch] = 0;
                    if (m_pend[ch]) begin
                        m_half[ch] = m_sh[ch];
                        m_pend[ch] = 1'b0;
                    end
                end else begin
                    m_pos[ch] = m_pos[ch] + 1;
                end
                if (a_en)                          m_mode[ch] = 1;
                else if (old_mode == 1)            m_mode[ch] = 2;
                else if (bnd && !m_level[ch])      m_mode[ch] = 0;
            end
            if (wr_acc && (a_sel == ch[0])) begin
                if (old_mode == 0) m_half[ch] = a_div;
                else begin
                    m_sh[ch] = a_div;
                    m_pend[ch] = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive(input bit en, input bit v, input bit s, input int d);
        logic [31:0] dv;
        obs_t e;
        @(posedge clk);
        model_step();
        #1;
        dv = d;
        bus.enable = en; bus.cfg_valid = v; bus.cfg_sel = s; bus.cfg_div = dv[CNT_W-1:0];
        a_en = en; a_valid = v; a_sel = s; a_div = d;
        e = {m_tick[0], m_level[0], m_tick[1], m_level[1],
             m_pend[0] | m_pend[1], (m_mode[0] != 0) || (m_mode[1] != 0), !m_pend[s]};
        sb_q.push_back(e);
    endtask

    task automatic idle_cycles(input bit en, input int n);
        for (int i = 0; i < n; i++) drive(en, 1'b0, 1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        obs_t act;
        obs_t exp_v;
        exp_v = 7'b000_0001;
        act = {bus.fsm_tick, bus.fsm_clk_level, bus.ila_tick, bus.ila_clk_level,
               bus.busy, bus.running, bus.cfg_ready};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%b expected=%b (ft fl it il busy run ready)", name, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        obs_t e;
        obs_t act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {bus.fsm_tick, bus.fsm_clk_level, bus.ila_tick, bus.ila_clk_level,
                       bus.busy, bus.running, bus.cfg_ready};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got=%b expected=%b (ft fl it il busy run ready)",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.enable = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_div = {CNT_W{1'b0}};
        model_reset();
        rst_n = 1'b0;
        #3;
        check_reset_outputs("reset_initial");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Configure while idle, then run.
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 0);
        idle_cycles(1'b1, 20);
        // Mid-period update to the FSM channel.
        drive(1'b1, 1'b1, 1'b0, 1);
        idle_cycles(1'b1, 12);
        // Write landing exactly on a wrap cycle.
        guard = 0;
        while (!(m_mode[0] == 1 && !m_pend[0] && m_half[0] >= 1 && m_pos[0] == m_half[0] - 1)
               && guard < 20) begin
            drive(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 4);
        idle_cycles(1'b1, 24);
        // Graceful stop from a low level at div 2.
        drive(1'b1, 1'b1, 1'b0, 2);
        idle_cycles(1'b1, 12);
        guard = 0;
        while (m_level[0] != 1'b0 && guard < 20) begin
            drive(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        idle_cycles(1'b0, 20);
        // Re-raise enable during stopping.
        idle_cycles(1'b1, 10);
        idle_cycles(1'b0, 1);
        idle_cycles(1'b1, 10);

        // Random operation.
        for (int i = 0; i < 2500; i++) begin
            bit en_n;
            en_n = ($urandom_range(0, 15) == 0) ? !a_en : a_en;
            drive(en_n, ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7));
        end

        // Leave a pending FSM update, then reset mid-period.
        idle_cycles(1'b1, 4);
        guard = 0;
        while (m_pend[0] && guard < 40) begin
            drive(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 40);
        drive(1'b1, 1'b0, 1'b0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_sel = 1'b0;
        #1;
        check_reset_outputs("reset_async_sel0");
        bus.cfg_sel = 1'b1;
        #1;
        check_reset_outputs("reset_async_sel1");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset divisors: FSM half-period of 126 cycles.
        idle_cycles(1'b1, 300);
        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable two-channel clock-enable scheduler for the board's slow derived timebases: the I2C FSM timebase and the ILA sampling timebase. It runs on the single buffered system clock and generates per-channel one-cycle tick enables and divided level signals. Divisor changes arrive through a valid/ready configuration port and take effect only at a period boundary, so no runt or stretched phase is ever produced. Enable/disable sequencing is graceful: a channel always stops with its level low.

Parameters:
CNT_W, 24, width of divisor and counter registers
FSM_DIV_RST, 125, FSM channel active divisor after reset
ILA_DIV_RST, 250000, ILA channel active divisor after reset

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request, applies to both channels
cfg_valid  in  1  divisor write request
cfg_sel  in  1  channel select: 0 = FSM, 1 = ILA
cfg_div  in  CNT_W  new divisor; half-period = cfg_div+1 clk cycles
cfg_ready  out  1  selected channel can accept a write
fsm_tick  out  1  one-cycle pulse at each FSM half-period boundary
fsm_clk_level  out  1  FSM divided level, toggles on each fsm_tick
ila_tick  out  1  one-cycle pulse at each ILA half-period boundary
ila_clk_level  out  1  ILA divided level, toggles on each ila_tick
busy  out  1  OR of both channels' pending-update flags
running  out  1  high when either channel is not IDLE

Behaviour:
- Per-channel registers:
  - cnt[CNT_W]
  - div_act (resets to the channel's *_DIV_RST)
  - div_sh
  - pend
  - level
  - tick
  - state
- Reset (async, rst_n low):
  - every state = IDLE; cnt = 0; pend = 0; div_sh = 0.
  - all ticks = 0; all levels = 0.
  - busy = 0; running = 0.
  - cfg_ready = 1 for both channels.
- Channel FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - cnt held at 0; level = 0; tick = 0.
  - enable = 1 -> RUN next cycle, with cnt = 0.
- RUN and STOPPING (counting states), each cycle:
  - if cnt == div_act: cnt <= 0, tick <= 1, level <= ~level, and if pend then div_act <= div_sh, pend <= 0.
  - else: cnt <= cnt + 1, tick <= 0.
- tick and level are registered. The tick pulse and the level toggle appear together, one cycle after the cycle where cnt == div_act.
- Half-period = div_act+1 cycles. div_act = 0 is legal: tick is asserted every cycle and level toggles every cycle.
- RUN with enable = 0 -> STOPPING. Counting continues unchanged.
- STOPPING:
  - enable = 1 -> RUN; count and level are undisturbed.
  - At a wrap where level is currently 1 (toggling to 0): -> IDLE with cnt = 0. The final tick is still emitted.
  - At a wrap where level is 0: toggle to 1, stay in STOPPING.
- Config handshake:
  - cfg_ready = ~pend of the channel chosen by cfg_sel (combinational on cfg_sel).
  - Write accepted when cfg_valid && cfg_ready.
  - Channel in IDLE: div_act <= cfg_div next cycle; pend stays 0.
  - Channel in RUN/STOPPING: div_sh <= cfg_div, pend <= 1.
  - A write accepted in the same cycle as that channel's wrap sets pend. It applies at the following wrap, never the coincident one.
  - A write to one channel never affects the other channel.
- busy = pend_fsm | pend_ila.
- running = (fsm state != IDLE) | (ila state != IDLE).
- Channels are independent. They are released together by enable but may reach IDLE on different cycles.
- Counter never exceeds div_act, because divisor changes apply only when cnt returns to 0. No arithmetic overflow is possible.
- Reset asserted mid-operation forces all reset values immediately, including clearing any pending update.

Test Plan:
1. Reset values; write FSM div = 3 while IDLE; raise enable -> first fsm_tick 4 cycles after the RUN entry cycle, repeating every 4 cycles; fsm_clk_level period 8 cycles; running = 1.
2. FSM running at div = 3; write div = 1 mid-period -> busy = 1 and cfg_ready (sel = 0) = 0 until the next tick; the following half-periods are 2 cycles; busy = 0 after the switch.
3. Write accepted exactly on the cycle cnt == div_act -> current wrap uses the old divisor; the new divisor applies one full half-period later.
4. Drop enable while FSM level = 0 (div = 2) -> one more high phase (3 cycles); state IDLE after the falling toggle; level = 0; running drops once the ILA channel (div = 0) is also idle.
5. div = 0 on the ILA channel -> ila_tick high every cycle, ila_clk_level toggling every cycle; re-raising enable during STOPPING keeps the phase continuous.
6. Assert rst_n low mid-period with pend = 1 -> all outputs return to reset values asynchronously; div_act = 125 / 250000; pend cleared.
